// File: rtl/p_bool_pkg.sv
// Shared definitions for the p_bool logic units: op codes, base-op select and FSM states.
package p_bool_pkg;

   localparam int OP_WIDTH = 3;
   localparam int INV      = 2;

   localparam logic [OP_WIDTH-1:0] OP_AND  = 3'd0;
   localparam logic [OP_WIDTH-1:0] OP_OR   = 3'd1;
   localparam logic [OP_WIDTH-1:0] OP_XOR  = 3'd2;
   localparam logic [OP_WIDTH-1:0] OP_NAND = 3'd4;
   localparam logic [OP_WIDTH-1:0] OP_NOR  = 3'd5;
   localparam logic [OP_WIDTH-1:0] OP_XNOR = 3'd6;

   // Base operation is op[1:0]; code 3 is an alias of OR.
   localparam logic [1:0] BASE_AND = 2'd0;
   localparam logic [1:0] BASE_OR  = 2'd1;
   localparam logic [1:0] BASE_XOR = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/p_bool_combine.sv
// Combinational fold step: next accumulator from (acc, operand, base op).
module p_bool_combine
   import p_bool_pkg::*;
#(
   parameter int BUS_WIDTH = 8
) (
   input  logic [BUS_WIDTH-1:0] i_acc,
   input  logic [BUS_WIDTH-1:0] i_operand,
   input  logic [1:0]           i_base,
   output logic [BUS_WIDTH-1:0] o_acc
);

   always_comb begin
      o_acc = i_acc | i_operand;
      case (i_base)
         BASE_AND: o_acc = i_acc & i_operand;
         BASE_XOR: o_acc = i_acc ^ i_operand;
         default:  o_acc = i_acc | i_operand;
      endcase
   end

endmodule

// File: rtl/p_bool_accum.sv
// Handshaked sequential boolean reduction over up to NB_INS operands.
// Define P_BOOL_ACCUM_ZERO_EN to add the registered out_zero flag.
module p_bool_accum
   import p_bool_pkg::*;
#(
   parameter int BUS_WIDTH = 8,
   parameter int NB_INS    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BUS_WIDTH-1:0] in_bus,
   input  logic [OP_WIDTH-1:0]  in_op,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BUS_WIDTH-1:0] out_bus,
   output logic [OP_WIDTH-1:0]  out_op
`ifdef P_BOOL_ACCUM_ZERO_EN
   ,
   output logic                 out_zero
`endif
);

   localparam int CNT_W = $clog2(NB_INS + 1);

   state_t               r_state;
   logic [BUS_WIDTH-1:0] r_acc;
   logic [OP_WIDTH-1:0]  r_op;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_out_valid;
   logic [BUS_WIDTH-1:0] r_out_bus;
   logic [OP_WIDTH-1:0]  r_out_op;
`ifdef P_BOOL_ACCUM_ZERO_EN
   logic                 r_out_zero;
`endif

   logic                 w_first;
   logic                 w_accept;
   logic                 w_term;
   logic [OP_WIDTH-1:0]  w_op;
   logic [BUS_WIDTH-1:0] w_comb;
   logic [BUS_WIDTH-1:0] w_acc_nxt;
   logic [BUS_WIDTH-1:0] w_result;
   logic [CNT_W-1:0]     w_cnt_nxt;

   p_bool_combine #(
      .BUS_WIDTH (BUS_WIDTH)
   ) u_combine (
      .i_acc     (r_acc),
      .i_operand (in_bus),
      .i_base    (r_op[1:0]),
      .o_acc     (w_comb)
   );

   // A beat accepted in DONE (result being consumed) starts a new reduction, like IDLE.
   always_comb begin
      in_ready  = (r_state == ST_DONE) ? out_ready : 1'b1;
      w_first   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
      w_accept  = in_valid && in_ready;
      w_op      = w_first ? in_op : r_op;
      w_acc_nxt = w_first ? in_bus : w_comb;
      w_cnt_nxt = w_first ? CNT_W'(1) : r_cnt + 1'b1;
      w_term    = in_last || (w_cnt_nxt == CNT_W'(NB_INS));
      w_result  = w_op[INV] ? ~w_acc_nxt : w_acc_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_acc       <= '0;
         r_op        <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_bus   <= '0;
         r_out_op    <= '0;
`ifdef P_BOOL_ACCUM_ZERO_EN
         r_out_zero  <= 1'b0;
`endif
      end else begin
         if ((r_state == ST_DONE) && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_op  <= w_op;
            r_cnt <= w_cnt_nxt;
            if (w_term) begin
               r_state     <= ST_DONE;
               r_out_valid <= 1'b1;
               r_out_bus   <= w_result;
               r_out_op    <= w_op;
`ifdef P_BOOL_ACCUM_ZERO_EN
               r_out_zero  <= (w_result == '0);
`endif
            end else begin
               r_state <= ST_ACCUM;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_bus   = r_out_bus;
   assign out_op    = r_out_op;
`ifdef P_BOOL_ACCUM_ZERO_EN
   assign out_zero  = r_out_zero;
`endif

endmodule

// File: doc/p_bool_accum.md
# p_bool_accum

Parametrised sequential boolean reduction engine. Accepts a stream of BUS_WIDTH-bit operands over a valid/ready handshake, folds up to NB_INS of them with a selectable operation (AND, OR, XOR, NAND, NOR, XNOR), and presents one registered result per reduction on a second valid/ready handshake. It sits in the CPU's logic path and generalises the fixed-fan-in combinational boolean gates with run-time operation select, variable operand count and back-pressure.

## Interface

- BUS_WIDTH, 8, operand and result width in bits (≥1)
- NB_INS, 4, maximum operands per reduction (≥1)

- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand beat valid
- in_ready  output  1  engine can accept a beat
- in_bus  input  BUS_WIDTH  operand
- in_op  input  3  operation, sampled only on first beat of a reduction
- in_last  input  1  beat is final operand (early termination)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_bus  output  BUS_WIDTH  reduction result
- out_op  output  3  operation that produced out_bus
- out_zero  output  1  only with P_BOOL_ACCUM_ZERO_EN (see Configuration)

## Operation

- Op encoding: in_op[1:0] selects base op (0 AND, 1 OR, 2 XOR); in_op[2] inverts the final result (4 NAND, 5 NOR, 6 XNOR). in_op[1:0]==3 behaves as OR; in_op[2] still applies.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: in_ready=1. Accepted beat loads acc=in_bus, latches op, count=1. If in_last or NB_INS==1 → DONE, else → ACCUM.
- ACCUM: in_ready=1. Accepted beat: acc = acc <base op> in_bus, count+1. If in_last or count+1==NB_INS → DONE, else stay. No beat: hold.
- DONE: out_valid=1; out_bus = op[2] ? ~acc : acc; out_op = latched op. Outputs stable until out_ready. in_ready = out_ready.
- DONE with out_ready=1 and no input beat → IDLE. With out_ready=1 and in_valid=1: beat treated as IDLE first beat (back-to-back), next state ACCUM or DONE per IDLE rules.
- in_op on non-first beats ignored. in_last on a beat that also reaches NB_INS: single termination, no effect beyond that.
- Counter width $clog2(NB_INS+1); never exceeds NB_INS.

## Timing

- Reset values: state IDLE, in_ready=1 (combinational from IDLE), out_valid=0, out_bus=0, out_op=0, out_zero=0, acc=0, count=0.
- Reset asserted mid-reduction or while DONE: partial result discarded, out_valid drops immediately (asynchronous).
- Latency: result valid the cycle after the terminating beat is accepted.
- Throughput: one reduction of N beats every N cycles with out_ready held high.
- in_ready in DONE is combinational on out_ready; no other comb paths from inputs to outputs.

## Configuration

- P_BOOL_ACCUM_ZERO_EN defined: out_zero port present, registered alongside out_bus, 1 iff final (post-inversion) result is all zeros; 0 at reset.
- Undefined: out_zero port and its logic absent; all other behaviour identical.

## Structure

- Shared package p_bool_pkg: OP_WIDTH=3, op code constants (OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR), INV bit index, FSM state typedef.
- One sub-module: p_bool_combine, combinational (acc, operand, base op) → next acc, reusable by other logic units.

## Test plan

- BUS_WIDTH=8, NB_INS=4, op=NOR(5), beats 0x01,0x02,0x04,0x08 back-to-back → one cycle after 4th beat out_valid=1, out_bus=0xF0, out_op=5.
- op=XOR(2), beats 0xFF,0x0F with in_last on second → out_bus=0xF0 after 2 beats; in_ready=0 while out_ready=0.
- Result held with out_ready=0 for 5 cycles → out_bus/out_valid stable; then out_ready=1 together with new first beat (op=AND, 0xAA) → accepted same cycle, next reduction begins.
- NB_INS=1, op=NAND(4), beat 0x3C → out_bus=0xC3 next cycle.
- rst pulsed after 2 of 4 beats → out_valid=0, state IDLE; fresh OR reduction 0x00×4 → out_bus=0x00, out_zero=1 (with P_BOOL_ACCUM_ZERO_EN).
- op=3, beats 0x10,0x01 in_last → out_bus=0x11 (OR behaviour).
